// File: rtl/dice_rf_addr_pkg.sv
// dice_rf_addr_pkg
//   Shared types for the DICE register-file address generator.
//   addr_mode_e : per-bank addressing mode (2-bit encoding, fixed by the
//                 cfg_mode port encoding).
//   bank_cfg_t  : one bank's configuration word {mode, value}.
//   The value field is sized for the widest supported address; the top
//   module checks at elaboration that its ADDR_WIDTH fits.
package dice_rf_addr_pkg;

  typedef enum logic [1:0] {
    MODE_TID    = 2'd0,  // addr = tid
    MODE_CONST  = 2'd1,  // addr = value
    MODE_OFFSET = 2'd2,  // addr = tid + value (wraps)
    MODE_MIRROR = 2'd3   // addr = value - tid (wraps)
  } addr_mode_e;

  localparam int CFG_VALUE_W = 16;

  typedef struct packed {
    addr_mode_e             mode;
    logic [CFG_VALUE_W-1:0] value;
  } bank_cfg_t;

  localparam bank_cfg_t CFG_RESET = '{mode: MODE_TID, value: '0};

endpackage

// File: rtl/dice_rf_addr_lane.sv
// dice_rf_addr_lane
//   Purely combinational address computation for one RF bank.
//   Ports:
//     tid  in  ADDR_WIDTH  dispatched thread id
//     cfg  in  bank_cfg_t  active configuration of this bank
//     addr out ADDR_WIDTH  bank address, modulo 2**ADDR_WIDTH
//     oob  out 1           unwrapped result left the bank (only when
//                          DICE_RF_ADDR_BOUNDS_CHECK_EN is defined,
//                          otherwise constant 0)
module dice_rf_addr_lane
  import dice_rf_addr_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic [ADDR_WIDTH-1:0] tid,
  input  bank_cfg_t             cfg,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  oob
);

  logic [ADDR_WIDTH-1:0] value;
  logic [ADDR_WIDTH-1:0] offset_addr;
  logic [ADDR_WIDTH-1:0] mirror_addr;

  assign value = cfg.value[ADDR_WIDTH-1:0];

  // The config value is never wider than ADDR_WIDTH in practice; the
  // spare storage bits above it are intentionally ignored.
  if (ADDR_WIDTH < CFG_VALUE_W) begin : g_value_hi
    logic unused_value_hi;
    assign unused_value_hi = ^cfg.value[CFG_VALUE_W-1:ADDR_WIDTH];
  end

`ifdef DICE_RF_ADDR_BOUNDS_CHECK_EN
  // One extra bit: carry-out flags an OFFSET result >= DEPTH, borrow-out
  // flags a negative MIRROR result.
  logic [ADDR_WIDTH:0] sum_wide;
  logic [ADDR_WIDTH:0] diff_wide;

  assign sum_wide    = {1'b0, tid} + {1'b0, value};
  assign diff_wide   = {1'b0, value} - {1'b0, tid};
  assign offset_addr = sum_wide[ADDR_WIDTH-1:0];
  assign mirror_addr = diff_wide[ADDR_WIDTH-1:0];

  always_comb begin
    oob = 1'b0;
    if (cfg.mode == MODE_OFFSET) begin
      oob = sum_wide[ADDR_WIDTH];
    end else if (cfg.mode == MODE_MIRROR) begin
      oob = diff_wide[ADDR_WIDTH];
    end
  end
`else
  assign offset_addr = tid + value;
  assign mirror_addr = value - tid;
  assign oob         = 1'b0;
`endif

  always_comb begin
    addr = tid;
    unique case (cfg.mode)
      MODE_TID:    addr = tid;
      MODE_CONST:  addr = value;
      MODE_OFFSET: addr = offset_addr;
      MODE_MIRROR: addr = mirror_addr;
    endcase
  end

endmodule

// File: rtl/dice_rf_addr_gen.sv
// dice_rf_addr_gen
//   Per-bank register-file address generator for the DICE CGRA core.
//   One accepted dispatch (thread id) produces NUM_BANK bank addresses,
//   each computed from that bank's ACTIVE configuration. Configuration is
//   double-buffered: cfg_we writes a shadow entry, cfg_commit copies all
//   shadow entries to active. The result sits in a single valid/ready
//   output register.
//   Optional feature: DICE_RF_ADDR_BOUNDS_CHECK_EN enables the sticky
//   err_oob flag; without it err_oob is constant 0.
//   Ports:
//     clk, reset                     clock, synchronous active-high reset
//     disp_valid/disp_ready/disp_tid dispatch input handshake
//     rf_valid/rf_ready/rf_tid       output handshake and carried tid
//     rf_addr                        bank i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//     cfg_we/cfg_bank/cfg_mode/cfg_value  shadow config write
//     cfg_commit                     shadow -> active copy
//     err_oob                        sticky out-of-bounds flag
module dice_rf_addr_gen
  import dice_rf_addr_pkg::*;
#(
  parameter int NUM_BANK   = 16,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BANK_IDX_W = $clog2(NUM_BANK)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [ADDR_WIDTH-1:0]          disp_tid,
  output logic                           rf_valid,
  input  logic                           rf_ready,
  output logic [ADDR_WIDTH-1:0]          rf_tid,
  output logic [NUM_BANK*ADDR_WIDTH-1:0] rf_addr,
  input  logic                           cfg_we,
  input  logic [BANK_IDX_W-1:0]          cfg_bank,
  input  logic [1:0]                     cfg_mode,
  input  logic [ADDR_WIDTH-1:0]          cfg_value,
  input  logic                           cfg_commit,
  output logic                           err_oob
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("dice_rf_addr_gen: DEPTH must be a power of two >= 2");
  end
  if (ADDR_WIDTH > CFG_VALUE_W) begin : g_width_chk
    $error("dice_rf_addr_gen: ADDR_WIDTH exceeds CFG_VALUE_W");
  end
  if (NUM_BANK < 2) begin : g_bank_chk
    $error("dice_rf_addr_gen: NUM_BANK must be at least 2");
  end

  // ---------------------------------------------------------------------
  // Configuration: shadow and active banks
  // ---------------------------------------------------------------------
  bank_cfg_t shadow_q [NUM_BANK];
  bank_cfg_t shadow_d [NUM_BANK];
  bank_cfg_t active_q [NUM_BANK];
  bank_cfg_t active_d [NUM_BANK];
  bank_cfg_t cfg_new;

  assign cfg_new = '{mode: addr_mode_e'(cfg_mode), value: CFG_VALUE_W'(cfg_value)};

  // Commit reads shadow_q, so a write in the same cycle lands only in the
  // shadow. An out-of-range cfg_bank matches no entry and is dropped.
  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      shadow_d[b] = shadow_q[b];
      active_d[b] = cfg_commit ? shadow_q[b] : active_q[b];
      if (cfg_we && (32'(cfg_bank) == b)) begin
        shadow_d[b] = cfg_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        shadow_q[b] <= CFG_RESET;
        active_q[b] <= CFG_RESET;
      end
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        shadow_q[b] <= shadow_d[b];
        active_q[b] <= active_d[b];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Address lanes
  // ---------------------------------------------------------------------
  logic [NUM_BANK*ADDR_WIDTH-1:0] lane_addr;
  logic [NUM_BANK-1:0]            lane_oob;

  for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_lane
    dice_rf_addr_lane #(
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane (
      .tid  (disp_tid),
      .cfg  (active_q[gi]),
      .addr (lane_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]),
      .oob  (lane_oob[gi])
    );
  end

  // ---------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------
  logic                           rf_valid_q, rf_valid_d;
  logic [ADDR_WIDTH-1:0]          rf_tid_q, rf_tid_d;
  logic [NUM_BANK*ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic                           accept;

  // Ready whenever the stage is empty or draining this cycle: a new word
  // replaces a consumed one with no bubble.
  assign disp_ready = !rf_valid_q || rf_ready;
  assign accept     = disp_valid && disp_ready;

  always_comb begin
    rf_valid_d = rf_valid_q;
    rf_tid_d   = rf_tid_q;
    rf_addr_d  = rf_addr_q;
    if (accept) begin
      rf_valid_d = 1'b1;
      rf_tid_d   = disp_tid;
      rf_addr_d  = lane_addr;
    end else if (rf_ready) begin
      rf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_valid_q <= 1'b0;
      rf_tid_q   <= '0;
      rf_addr_q  <= '0;
    end else begin
      rf_valid_q <= rf_valid_d;
      rf_tid_q   <= rf_tid_d;
      rf_addr_q  <= rf_addr_d;
    end
  end

  assign rf_valid = rf_valid_q;
  assign rf_tid   = rf_tid_q;
  assign rf_addr  = rf_addr_q;

`ifdef DICE_RF_ADDR_BOUNDS_CHECK_EN
  logic err_oob_q, err_oob_d;

  always_comb begin
    err_oob_d = err_oob_q;
    if (accept && (|lane_oob)) begin
      err_oob_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_oob_q <= 1'b0;
    end else begin
      err_oob_q <= err_oob_d;
    end
  end

  assign err_oob = err_oob_q;
`else
  logic unused_lane_oob;
  assign unused_lane_oob = |lane_oob;
  assign err_oob         = 1'b0;
`endif

endmodule

// File: tb/tb_dice_rf_addr_gen.sv
// tb_dice_rf_addr_gen
//   Directed self-checking bench for dice_rf_addr_gen (NUM_BANK=16,
//   DEPTH=512). Inputs change 1 ns after the rising edge and outputs are
//   sampled at the same point, i.e. they reflect the preceding edge.
module tb_dice_rf_addr_gen;

  localparam int NB = 16;
  localparam int AW = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              disp_valid;
  logic              disp_ready;
  logic [AW-1:0]     disp_tid;
  logic              rf_valid;
  logic              rf_ready;
  logic [AW-1:0]     rf_tid;
  logic [NB*AW-1:0]  rf_addr;
  logic              cfg_we;
  logic [3:0]        cfg_bank;
  logic [1:0]        cfg_mode;
  logic [AW-1:0]     cfg_value;
  logic              cfg_commit;
  logic              err_oob;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dice_rf_addr_gen #(
    .NUM_BANK (NB),
    .DEPTH    (512)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .disp_tid   (disp_tid),
    .rf_valid   (rf_valid),
    .rf_ready   (rf_ready),
    .rf_tid     (rf_tid),
    .rf_addr    (rf_addr),
    .cfg_we     (cfg_we),
    .cfg_bank   (cfg_bank),
    .cfg_mode   (cfg_mode),
    .cfg_value  (cfg_value),
    .cfg_commit (cfg_commit),
    .err_oob    (err_oob)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bank(input int b);
    return 32'(rf_addr[b*AW +: AW]);
  endfunction

  task automatic cfg_write(input logic [3:0] b, input logic [1:0] m, input logic [AW-1:0] v);
    cfg_we = 1'b1; cfg_bank = b; cfg_mode = m; cfg_value = v;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  // One-cycle dispatch; the word appears in the output stage afterwards.
  task automatic dispatch(input logic [AW-1:0] t);
    disp_valid = 1'b1; disp_tid = t;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] exp);
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("%s_b%0d", tag, b), bank(b), exp);
    end
  endtask

  initial begin
    reset = 1'b1; disp_valid = 1'b0; disp_tid = '0; rf_ready = 1'b1;
    cfg_we = 1'b0; cfg_bank = '0; cfg_mode = '0; cfg_value = '0; cfg_commit = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_valid", 32'(rf_valid), 0);
    chk("rst_tid", 32'(rf_tid), 0);
    chk("rst_addr_or", 32'(|rf_addr), 0);
    chk("rst_oob", 32'(err_oob), 0);
    chk("rst_disp_ready", 32'(disp_ready), 1);

    // 1: default MODE_TID everywhere, one-cycle latency
    dispatch(9'd5);
    $display("T1 tid=5 rf_valid=%0d rf_tid=%0d", rf_valid, rf_tid);
    chk("t1_valid", 32'(rf_valid), 1);
    chk("t1_tid", 32'(rf_tid), 5);
    chk_all("t1_addr", 5);
    tick();
    chk("t1_drain", 32'(rf_valid), 0);

    // 2: shadow write is invisible until commit
    cfg_write(4'd3, 2'd1, 9'd100);
    dispatch(9'd7);
    $display("T2a tid=7 bank3=%0d", bank(3));
    chk("t2_precommit_b3", bank(3), 7);
    commit();
    dispatch(9'd7);
    $display("T2b tid=7 bank3=%0d", bank(3));
    chk("t2_commit_b3", bank(3), 100);
    chk("t2_commit_b2", bank(2), 7);

    // 3: wrapping OFFSET and MIRROR
    cfg_write(4'd0, 2'd2, 9'd510);
    cfg_write(4'd1, 2'd3, 9'd2);
    commit();
    dispatch(9'd4);
    $display("T3 tid=4 bank0=%0d bank1=%0d err_oob=%0d", bank(0), bank(1), err_oob);
    chk("t3_offset_b0", bank(0), 2);
    chk("t3_mirror_b1", bank(1), 510);
    chk("t3_const_b3", bank(3), 100);
`ifdef DICE_RF_ADDR_BOUNDS_CHECK_EN
    chk("t3_oob", 32'(err_oob), 1);
`else
    chk("t3_oob", 32'(err_oob), 0);
`endif
    tick();

    // 4: backpressure holds the word, then back-to-back drain
    rf_ready = 1'b0;
    dispatch(9'd9);
    disp_valid = 1'b1; disp_tid = 9'd1;
    for (int c = 0; c < 3; c++) begin
      tick();
      $display("T4 stall c=%0d rf_tid=%0d disp_ready=%0d", c, rf_tid, disp_ready);
      chk($sformatf("t4_hold_valid%0d", c), 32'(rf_valid), 1);
      chk($sformatf("t4_hold_tid%0d", c), 32'(rf_tid), 9);
      chk($sformatf("t4_hold_b0_%0d", c), bank(0), 7);   // 9+510 mod 512
      chk($sformatf("t4_dready%0d", c), 32'(disp_ready), 0);
    end
    rf_ready = 1'b1;
    #1;
    chk("t4_dready_release", 32'(disp_ready), 1);
    for (int t = 1; t <= 3; t++) begin
      disp_tid = AW'(t);
      tick();
      $display("T4 drain tid=%0d rf_tid=%0d", t, rf_tid);
      chk($sformatf("t4_b2b_valid%0d", t), 32'(rf_valid), 1);
      chk($sformatf("t4_b2b_tid%0d", t), 32'(rf_tid), 32'(t));
    end
    chk("t4_b0_tid3", bank(0), 1);     // 3+510 mod 512
    chk("t4_b1_tid3", bank(1), 511);   // 2-3 mod 512
    disp_valid = 1'b0;
    tick();
    chk("t4_empty", 32'(rf_valid), 0);

    // 5: commit coincident with accept uses the old active config
    cfg_write(4'd5, 2'd1, 9'd42);
    cfg_commit = 1'b1;
    dispatch(9'd11);
    cfg_commit = 1'b0;
    $display("T5a tid=11 bank5=%0d", bank(5));
    chk("t5_same_cycle_b5", bank(5), 11);
    dispatch(9'd12);
    $display("T5b tid=12 bank5=%0d", bank(5));
    chk("t5_next_b5", bank(5), 42);
    tick();
    // a commit does not disturb a held output word
    rf_ready = 1'b0;
    dispatch(9'd13);
    cfg_write(4'd6, 2'd1, 9'd77);
    commit();
    $display("T5c held tid=%0d bank6=%0d", rf_tid, bank(6));
    chk("t5_held_b6", bank(6), 13);
    chk("t5_held_tid", 32'(rf_tid), 13);

    // 6: reset while stalled drops the word and restores MODE_TID
    chk("t6_pre_valid", 32'(rf_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("T6 after reset rf_valid=%0d rf_tid=%0d", rf_valid, rf_tid);
    chk("t6_valid", 32'(rf_valid), 0);
    chk("t6_tid", 32'(rf_tid), 0);
    chk("t6_oob", 32'(err_oob), 0);
    rf_ready = 1'b1;
    dispatch(9'd20);
    chk_all("t6_addr", 20);
    commit();
    dispatch(9'd20);
    $display("T6 post-commit bank0=%0d bank5=%0d", bank(0), bank(5));
    chk("t6_shadow_b0", bank(0), 20);
    chk("t6_shadow_b5", bank(5), 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
